// File: rtl/puf_pkg.sv
// Shared definitions for the PUF challenge sequencer.
//   PUF_KEY_W       : width of the key byte returned by the PUF core
//   puf_seq_state_t : sequencer FSM states
//   clog2()         : elaboration-time ceil(log2(value)); returns 0 for value <= 1
package puf_pkg;

  localparam int PUF_KEY_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_MEAS   = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_VOTE   = 3'd5,
    S_DONE   = 3'd6
  } puf_seq_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/puf_majority_voter.sv
// Eight-lane majority voter for repeated PUF key measurements.
// Each lane counts how many measurements returned a 1 for that key bit.
//   clk, reset   : clock, synchronous active-high reset
//   clr          : zero all lane counters (wins over acc)
//   acc          : add key[b] into lane b
//   key          : key byte being accumulated
//   voted        : per-lane majority (count > REPEATS/2), from the counters
//   disagree_cnt : lanes whose count is neither 0 nor REPEATS
module puf_majority_voter
  import puf_pkg::*;
#(
  parameter int REPEATS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 acc,
  input  logic [PUF_KEY_W-1:0] key,
  output logic [PUF_KEY_W-1:0] voted,
  output logic [3:0]           disagree_cnt
);

  localparam int CW = (clog2(REPEATS + 1) < 1) ? 1 : clog2(REPEATS + 1);
  localparam logic [CW-1:0] FULL = CW'(REPEATS);
  localparam logic [CW-1:0] HALF = CW'(REPEATS / 2);

  logic [CW-1:0] cnt_q [PUF_KEY_W];
  logic [CW-1:0] cnt_d [PUF_KEY_W];

  always_comb begin
    for (int b = 0; b < PUF_KEY_W; b++) begin
      cnt_d[b] = cnt_q[b];
      if (clr)      cnt_d[b] = '0;
      else if (acc) cnt_d[b] = cnt_q[b] + CW'(key[b]);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < PUF_KEY_W; b++) begin
      if (reset) cnt_q[b] <= '0;
      else       cnt_q[b] <= cnt_d[b];
    end
  end

  always_comb begin
    voted        = '0;
    disagree_cnt = '0;
    for (int b = 0; b < PUF_KEY_W; b++) begin
      voted[b] = (cnt_q[b] > HALF);
      if ((cnt_q[b] != '0) && (cnt_q[b] != FULL)) disagree_cnt = disagree_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sweeps N_CHAL challenges through an RO PUF core, measuring each REPEATS
// times (clear -> measure -> settle -> sample) and majority-voting the key.
//   clk, reset   : clock, synchronous active-high reset (aborts a sweep)
//   start        : begin a sweep; only looked at in IDLE
//   busy         : high while a sweep is in progress (through DONE)
//   done         : one-cycle pulse at the end of a sweep
//   chal         : challenge byte presented to the PUF core
//   puf_en       : ring-oscillator / counter enable
//   puf_clr      : counter / buffer clear
//   key          : key byte from the PUF core, read only in SAMPLE
//   response     : voted keys, challenge i in [8i+7:8i]
//   unstable_cnt : number of key bits whose measurements disagreed
// Valid/ready note: there is no backpressure; start is a request accepted
// only in IDLE, and done is a single-cycle completion strobe.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int          N_CHAL        = 16,
  parameter int          REPEATS       = 3,
  parameter int          CLR_CYCLES    = 4,
  parameter int          MEAS_CYCLES   = 1024,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [7:0]  CHAL_BASE     = 8'h00,
  parameter logic [7:0]  CHAL_STEP     = 8'h01
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [7:0]                      chal,
  output logic                            puf_en,
  output logic                            puf_clr,
  input  logic [7:0]                      key,
  output logic [8*N_CHAL-1:0]             response,
  output logic [$clog2(8*N_CHAL+1)-1:0]   unstable_cnt
);

  localparam int UW     = $clog2(8 * N_CHAL + 1);
  localparam int MAX_PH = (CLR_CYCLES > MEAS_CYCLES)
                          ? ((CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES)
                          : ((MEAS_CYCLES > SETTLE_CYCLES) ? MEAS_CYCLES : SETTLE_CYCLES);
  localparam int TW     = (clog2(MAX_PH) < 1) ? 1 : clog2(MAX_PH);
  localparam int RW     = (clog2(REPEATS) < 1) ? 1 : clog2(REPEATS);
  localparam int IW     = (clog2(N_CHAL) < 1) ? 1 : clog2(N_CHAL);

  // Timer loads are "cycles - 1": the phase ends in the cycle the timer reads 0.
  localparam logic [TW-1:0] CLR_LOAD    = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] MEAS_LOAD   = TW'(MEAS_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST    = RW'(REPEATS - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N_CHAL - 1);

  puf_seq_state_t        state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [RW-1:0]         rep_q, rep_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            chal_q, chal_d;
  logic [8*N_CHAL-1:0]   response_q, response_d;
  logic [UW-1:0]         unstable_q, unstable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  puf_en_q, puf_en_d;
  logic                  puf_clr_q, puf_clr_d;

  logic                  voter_clr, voter_acc;
  logic [7:0]            voted;
  logic [3:0]            disagree_cnt;
  logic [UW:0]           unst_sum;

  assign voter_clr = ((state_q == S_IDLE) && start) || (state_q == S_VOTE);
  assign voter_acc = (state_q == S_SAMPLE);

  puf_majority_voter #(.REPEATS(REPEATS)) u_voter (
    .clk          (clk),
    .reset        (reset),
    .clr          (voter_clr),
    .acc          (voter_acc),
    .key          (key),
    .voted        (voted),
    .disagree_cnt (disagree_cnt)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rep_d      = rep_q;
    idx_d      = idx_q;
    chal_d     = chal_q;
    response_d = response_q;
    unstable_d = unstable_q;
    unst_sum   = {1'b0, unstable_q} + (UW+1)'(disagree_cnt);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          timer_d    = CLR_LOAD;
          idx_d      = '0;
          rep_d      = '0;
          chal_d     = CHAL_BASE;
          response_d = '0;
          unstable_d = '0;
        end
      end
      S_CLEAR: begin
        if (timer_q == '0) begin
          state_d = S_MEAS;
          timer_d = MEAS_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_MEAS: begin
        if (timer_q == '0) begin
          state_d = S_SETTLE;
          timer_d = SETTLE_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) begin
          state_d = S_SAMPLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_SAMPLE: begin
        timer_d = '0;
        if (rep_q != REP_LAST) begin
          rep_d   = rep_q + RW'(1);
          state_d = S_CLEAR;
          timer_d = CLR_LOAD;
        end else begin
          state_d = S_VOTE;
        end
      end
      S_VOTE: begin
        timer_d = '0;
        response_d[{idx_q, 3'b000} +: 8] = voted;
        unstable_d = unst_sum[UW] ? '1 : unst_sum[UW-1:0];
        rep_d = '0;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          chal_d  = chal_q + CHAL_STEP;
          state_d = S_CLEAR;
          timer_d = CLR_LOAD;
        end
      end
      S_DONE: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with state_q
    // while coming straight from flops.
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    puf_clr_d = (state_d == S_CLEAR);
    puf_en_d  = (state_d == S_MEAS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      rep_q      <= '0;
      idx_q      <= '0;
      chal_q     <= CHAL_BASE;
      response_q <= '0;
      unstable_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      puf_en_q   <= 1'b0;
      puf_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rep_q      <= rep_d;
      idx_q      <= idx_d;
      chal_q     <= chal_d;
      response_q <= response_d;
      unstable_q <= unstable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      puf_en_q   <= puf_en_d;
      puf_clr_q  <= puf_clr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign chal         = chal_q;
  assign puf_en       = puf_en_q;
  assign puf_clr      = puf_clr_q;
  assign response     = response_q;
  assign unstable_cnt = unstable_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;

  localparam int N       = 2;
  localparam int C       = 2;
  localparam int M       = 8;
  localparam int S       = 2;
  localparam int REP_LAT = C + M + S + 1;
  localparam int UW      = $clog2(8 * N + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              start0 = 1'b0, start1 = 1'b0;
  logic [7:0]        key0 = '0, key1 = '0;
  logic              busy0, done0, en0, clr0;
  logic              busy1, done1, en1, clr1;
  logic [7:0]        chal0, chal1;
  logic [8*N-1:0]    resp0, resp1;
  logic [UW-1:0]     unst0, unst1;

  puf_challenge_sequencer #(
    .N_CHAL(N), .REPEATS(3), .CLR_CYCLES(C), .MEAS_CYCLES(M), .SETTLE_CYCLES(S),
    .CHAL_BASE(8'h10), .CHAL_STEP(8'h01)
  ) dut (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .chal(chal0), .puf_en(en0), .puf_clr(clr0), .key(key0),
    .response(resp0), .unstable_cnt(unst0)
  );

  puf_challenge_sequencer #(
    .N_CHAL(N), .REPEATS(1), .CLR_CYCLES(C), .MEAS_CYCLES(M), .SETTLE_CYCLES(S),
    .CHAL_BASE(8'hFF), .CHAL_STEP(8'h01)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .chal(chal1), .puf_en(en1), .puf_clr(clr1), .key(key1),
    .response(resp1), .unstable_cnt(unst1)
  );

  // Observation mux: the sweep task looks at whichever instance is selected.
  bit            sel = 1'b0;
  logic          o_busy, o_done, o_en, o_clr;
  logic [7:0]    o_chal;
  logic [8*N-1:0] o_resp;
  logic [UW-1:0] o_unst;
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_en   = sel ? en1   : en0;
  assign o_clr  = sel ? clr1  : clr0;
  assign o_chal = sel ? chal1 : chal0;
  assign o_resp = sel ? resp1 : resp0;
  assign o_unst = sel ? unst1 : unst0;

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] key_tab [N][3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag, input logic [7:0] base);
    check({tag, "_busy"},    32'(o_busy), 32'd0);
    check({tag, "_done"},    32'(o_done), 32'd0);
    check({tag, "_chal"},    32'(o_chal), 32'(base));
    check({tag, "_en"},      32'(o_en),   32'd0);
    check({tag, "_clr"},     32'(o_clr),  32'd0);
    check({tag, "_resp"},    32'(o_resp), 32'd0);
    check({tag, "_unstable"},32'(o_unst), 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic drive_key(input bit s, input logic [7:0] v);
    if (s) key1 = v; else key0 = v;
  endtask

  task automatic drive_start(input bit s, input logic v);
    if (s) start1 = v; else start0 = v;
  endtask

  // One sweep. Called at #1 after a rising edge; that cycle is cycle 0 (start
  // accepted at the following edge). Key holds the scheduled value only in the
  // cycle the sequence should be in SAMPLE and is random otherwise.
  task automatic run_sweep(input bit s, input int n_cycles, input int restart_at, input int reset_at);
    int         r_n     = s ? 1 : 3;
    int         ch_lat  = r_n * REP_LAT + 1;
    int         done_at = N * ch_lat + 1;
    logic [7:0] base    = s ? 8'hFF : 8'h10;
    int         done_cnt = 0, done_t = -1, overlap = 0, clr_run = 0, en_run = 0;
    logic       prev_clr = 1'b0, prev_en = 1'b0;
    int         clr_lens[$], en_lens[$];
    logic [7:0] chal_seen[$];
    logic [8*N-1:0] exp_resp = '0;
    int         exp_unst = 0;

    sel = s;
    exp_q.delete();
    for (int i = 0; i < N; i++)
      for (int r = 0; r < r_n; r++) exp_q.push_back(base + 8'(i));

    drive_start(s, 1'b1);
    for (int t = 1; t <= n_cycles; t++) begin
      int w, i;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0; reset = 1'b0;

      if (o_clr && !prev_clr) chal_seen.push_back(o_chal);
      if (o_clr) clr_run++;
      else if (prev_clr) begin clr_lens.push_back(clr_run); clr_run = 0; end
      if (o_en) en_run++;
      else if (prev_en) begin en_lens.push_back(en_run); en_run = 0; end
      if (o_clr && o_en) overlap++;
      if (o_done) begin done_cnt++; done_t = t; end
      prev_clr = o_clr;
      prev_en  = o_en;

      if (t == 1) begin
        check("busy_after_accept", 32'(o_busy), 32'd1);
        check("resp_cleared_on_accept", 32'(o_resp), 32'd0);
      end
      if (reset_at == 0 && t == done_at)     check("busy_in_done", 32'(o_busy), 32'd1);
      if (reset_at == 0 && t == done_at + 1) check("busy_after_done", 32'(o_busy), 32'd0);
      if (reset_at > 0 && t == reset_at + 1) check_reset_values("abort", base);

      w = (t - 1) % ch_lat;
      i = (t - 1) / ch_lat;
      if (i < N && w < r_n * REP_LAT && (w % REP_LAT) == REP_LAT - 1)
        drive_key(s, key_tab[i][w / REP_LAT]);
      else
        drive_key(s, 8'($urandom));
      if (t == restart_at) drive_start(s, 1'b1);
      if (t == reset_at) reset = 1'b1;
    end

    if (reset_at > 0) begin
      check("no_done_after_abort", 32'(done_cnt), 32'd0);
    end else begin
      // Reference: bitwise popcount over the repeats, majority and disagreement.
      for (int i = 0; i < N; i++) begin
        for (int b = 0; b < 8; b++) begin
          int ones = 0;
          for (int r = 0; r < r_n; r++) ones += int'(key_tab[i][r][b]);
          exp_resp[8*i + b] = (ones * 2 > r_n);
          if (ones != 0 && ones != r_n) exp_unst++;
        end
      end
      check("done_count", 32'(done_cnt), 32'd1);
      check("done_cycle", 32'(done_t), 32'(done_at));
      check("response", 32'(o_resp), 32'(exp_resp));
      check("unstable_cnt", 32'(o_unst), 32'(exp_unst));
      check("clr_en_overlap", 32'(overlap), 32'd0);
      check("clr_pulses", 32'(clr_lens.size()), 32'(N * r_n));
      check("en_pulses", 32'(en_lens.size()), 32'(N * r_n));
      foreach (clr_lens[k]) check("clr_len", 32'(clr_lens[k]), 32'(C));
      foreach (en_lens[k])  check("en_len", 32'(en_lens[k]), 32'(M));
      check("chal_count", 32'(chal_seen.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && chal_seen.size() > 0)
        check("chal_seq", 32'(chal_seen.pop_front()), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic fill_random_keys();
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 3; r++) key_tab[i][r] = 8'($urandom);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1; check_reset_values("reset0", 8'h10);
    sel = 1'b1; #1; check_reset_values("reset1", 8'hFF);
    reset = 1'b0;
    @(posedge clk); #1;

    // Constant key: every repeat agrees.
    for (int i = 0; i < N; i++) for (int r = 0; r < 3; r++) key_tab[i][r] = 8'hA5;
    run_sweep(1'b0, 84, 0, 0);

    // One unstable bit on challenge 0.
    key_tab[0][0] = 8'hF0; key_tab[0][1] = 8'hF1; key_tab[0][2] = 8'hF0;
    key_tab[1][0] = 8'h0F; key_tab[1][1] = 8'h0F; key_tab[1][2] = 8'h0F;
    run_sweep(1'b0, 84, 0, 0);

    // start re-pulsed mid-sweep is ignored.
    fill_random_keys();
    run_sweep(1'b0, 84, 30, 0);

    // Reset mid-sweep aborts with no done.
    fill_random_keys();
    run_sweep(1'b0, 84, 0, 50);

    // Single repeat, challenge wrap from 8'hFF.
    key_tab[0][0] = 8'h3C; key_tab[1][0] = 8'h3C;
    run_sweep(1'b1, 32, 0, 0);

    // Random keys with a randomly placed ignored start.
    for (int n = 0; n < 3; n++) begin
      fill_random_keys();
      run_sweep(1'b0, 84, $urandom_range(2, 81), 0);
    end
    key_tab[0][0] = 8'($urandom); key_tab[1][0] = 8'($urandom);
    run_sweep(1'b1, 32, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
